// File: rtl/baud_pkg.sv
// Shared definitions for the fractional baud generator:
// rate select codes, the standard rate table and the divisor math.
package baud_pkg;

    typedef enum logic [2:0] {
        BAUD_2400   = 3'd0,
        BAUD_4800   = 3'd1,
        BAUD_9600   = 3'd2,
        BAUD_19200  = 3'd3,
        BAUD_38400  = 3'd4,
        BAUD_57600  = 3'd5,
        BAUD_115200 = 3'd6,
        BAUD_CUSTOM = 3'd7
    } baud_sel_e;

    localparam int unsigned NUM_RATES = 7;

    localparam int unsigned BAUD_RATES [NUM_RATES] = '{
        2400, 4800, 9600, 19200, 38400, 57600, 115200
    };

    // Smallest usable integer part of a divisor
    localparam int unsigned MIN_INT_DIV = 2;

    // Rounded fixed-point divisor: clk * 2^frac / (rate * os)
    function automatic longint unsigned div_calc(
        input int unsigned clk_hz,
        input int unsigned rate,
        input int unsigned os,
        input int unsigned frac_bits
    );
        longint unsigned num;
        longint unsigned den;
        num = 64'(clk_hz) << frac_bits;
        den = 64'(rate) * 64'(os);
        return (num + den / 2) / den;
    endfunction

endpackage

// File: rtl/frac_tick_div.sv
// Fractional-N tick divider: periods of I or I+1 cycles, chosen
// by the carry of a phase accumulator so the mean period is I.F.
module frac_tick_div
    import baud_pkg::*;
#(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              clear,
    input  logic              run,
    input  logic [INT_W-1:0]  I,
    input  logic [FRAC_W-1:0] F,
    output logic              tick
);

    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              extra_q, extra_d;
    logic [INT_W:0]    last;

    assign last = {1'b0, I} + {{INT_W{1'b0}}, extra_q} - (INT_W+1)'(1);
    assign tick = run && !clear && ({1'b0, cnt_q} == last);

    // Next count and phase; a carry stretches the following period
    always_comb begin
        cnt_d   = cnt_q + INT_W'(1);
        acc_d   = acc_q;
        extra_d = extra_q;
        if (!run || clear) begin
            cnt_d   = '0;
            acc_d   = '0;
            extra_d = 1'b0;
        end else if (tick) begin
            cnt_d            = '0;
            {extra_d, acc_d} = {1'b0, acc_q} + {1'b0, F};
        end
    end

    // Divider state registers
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            extra_q <= extra_d;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Baud generator: picks a table or custom divisor, reloads on change,
// and derives sample, bit and bit-clock outputs from a fractional divider.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned FRAC_BITS   = 4
) (
    input  logic                           Clock,
    input  logic                           ResetN,
    input  logic                           Enable,
    input  logic [2:0]                     BaudSel,
    input  logic [DIV_WIDTH+FRAC_BITS-1:0] CustomDiv,
    output logic                           SampleTick,
    output logic                           BaudTick,
    output logic                           BaudClk,
    output logic                           RateChange,
    output logic [DIV_WIDTH+FRAC_BITS-1:0] DivActive
);

    localparam int unsigned DW  = DIV_WIDTH + FRAC_BITS;
    localparam int unsigned OSW = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0]  MIN_DIV = DW'(MIN_INT_DIV) << FRAC_BITS;
    localparam logic [DW-1:0]  RST_DIV = DW'(div_calc(CLK_FREQ_HZ,
        BAUD_RATES[0], OVERSAMPLE, FRAC_BITS));
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2);

    logic [DW-1:0]  cand [8];
    logic [DW-1:0]  sel_raw, sel_div;
    logic [DW-1:0]  div_q;
    logic           load, tick;
    logic           st_q, bt_q, bt_d, bclk_q, bclk_d, rc_q;
    logic [OSW-1:0] os_q, os_d;

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_tbl
        localparam longint unsigned D = div_calc(CLK_FREQ_HZ,
            BAUD_RATES[g], OVERSAMPLE, FRAC_BITS);
        assign cand[g] = DW'(D);
    end
    assign cand[BAUD_CUSTOM] = CustomDiv;

    assign sel_raw = cand[BaudSel];

    // Keep the integer part large enough for the divider to cycle
    always_comb begin
        sel_div = sel_raw;
        if (sel_raw[DW-1:FRAC_BITS] < DIV_WIDTH'(MIN_INT_DIV)) begin
            sel_div = MIN_DIV;
        end
    end

    assign load = (sel_div != div_q);

    frac_tick_div #(
        .INT_W  (DIV_WIDTH),
        .FRAC_W (FRAC_BITS)
    ) u_div (
        .Clock  (Clock),
        .ResetN (ResetN),
        .clear  (load),
        .run    (Enable),
        .I      (div_q[DW-1:FRAC_BITS]),
        .F      (div_q[FRAC_BITS-1:0]),
        .tick   (tick)
    );

    // Oversample position, bit boundary and bit-clock level
    always_comb begin
        os_d = os_q;
        bt_d = 1'b0;
        if (load || !Enable) begin
            os_d = '0;
        end else if (tick) begin
            bt_d = (os_q == OS_LAST);
            os_d = bt_d ? '0 : os_q + OSW'(1);
        end
        bclk_d = Enable && (os_d < OS_HALF);
    end

    // Registered divisor and outputs
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            div_q  <= RST_DIV;
            rc_q   <= 1'b0;
            st_q   <= 1'b0;
            bt_q   <= 1'b0;
            bclk_q <= 1'b0;
            os_q   <= '0;
        end else begin
            div_q  <= sel_div;
            rc_q   <= load;
            st_q   <= tick;
            bt_q   <= bt_d;
            bclk_q <= bclk_d;
            os_q   <= os_d;
        end
    end

    assign SampleTick = st_q;
    assign BaudTick   = bt_q;
    assign BaudClk    = bclk_q;
    assign RateChange = rc_q;
    assign DivActive  = div_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: tick times predicted from the closed form
// t_k = k*I + floor((k-1)*F/16) measured from each restart point.
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  sel;
    logic [19:0] cdiv;
    logic        st, bt, bc, rc;
    logic [19:0] dact;

    int n_checks = 0;
    int n_fail   = 0;

    int t       = 0;
    int seg_s   = 0;
    int n_ticks = 0;
    logic [19:0] exp_div;
    logic exp_st, exp_bt, exp_bc, exp_rc;

    always #5 clk = ~clk;

    baud_gen_frac dut (
        .Clock      (clk),
        .ResetN     (rst_n),
        .Enable     (en),
        .BaudSel    (sel),
        .CustomDiv  (cdiv),
        .SampleTick (st),
        .BaudTick   (bt),
        .BaudClk    (bc),
        .RateChange (rc),
        .DivActive  (dact)
    );

    function automatic logic [19:0] ref_div(input logic [2:0] s,
                                            input logic [19:0] c);
        logic [19:0] d;
        case (s)
            3'd0:    d = 20'd20833;
            3'd1:    d = 20'd10417;
            3'd2:    d = 20'd5208;
            3'd3:    d = 20'd2604;
            3'd4:    d = 20'd1302;
            3'd5:    d = 20'd868;
            3'd6:    d = 20'd434;
            default: d = c;
        endcase
        if (d[19:4] < 16'd2) d = 20'd32;
        return d;
    endfunction

    function automatic int tick_at(input int k, input logic [19:0] d);
        return k * int'(d[19:4]) + ((k - 1) * int'(d[3:0])) / 16;
    endfunction

    // Advance one clock; model predicts the outputs of the new cycle
    task automatic step();
        logic [19:0] sd;
        logic        e;
        sd = ref_div(sel, cdiv);
        e  = en;
        @(posedge clk);
        #1;
        t++;
        exp_st = 1'b0;
        exp_bt = 1'b0;
        exp_rc = 1'b0;
        if (sd !== exp_div) begin
            exp_div = sd;
            exp_rc  = 1'b1;
        end
        if (exp_rc || !e) begin
            seg_s   = t;
            n_ticks = 0;
            exp_bc  = e;
        end else begin
            if (t - seg_s == tick_at(n_ticks + 1, exp_div)) begin
                exp_st = 1'b1;
                n_ticks++;
                exp_bt = (n_ticks % 16 == 0);
            end
            exp_bc = (n_ticks % 16) < 8;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 3'd0;
        cdiv  = 20'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (st !== 1'b0) begin
            n_fail++; $display("FAIL reset_st got %b exp 0", st);
        end
        n_checks++;
        if (bt !== 1'b0) begin
            n_fail++; $display("FAIL reset_bt got %b exp 0", bt);
        end
        n_checks++;
        if (bc !== 1'b0) begin
            n_fail++; $display("FAIL reset_bc got %b exp 0", bc);
        end
        n_checks++;
        if (rc !== 1'b0) begin
            n_fail++; $display("FAIL reset_rc got %b exp 0", rc);
        end
        n_checks++;
        if (dact !== 20'd20833) begin
            n_fail++; $display("FAIL reset_div got %0d exp 20833", dact);
        end
        rst_n   = 1'b1;
        t       = 0;
        seg_s   = 0;
        n_ticks = 0;
        exp_div = 20'd20833;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL idle t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
        end
    endtask

    task automatic test_rate_115200();
        int bts[$];
        en  = 1'b1;
        sel = 3'd6;
        for (int i = 0; i < 1400; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL b115200 t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
            if (i == 0) begin
                n_checks++;
                if (rc !== 1'b1) begin
                    n_fail++; $display("FAIL b115200_load rc=%b exp 1", rc);
                end
            end
            if (bt) bts.push_back(t);
        end
        n_checks++;
        if (bts.size() < 3 || bts[2] - bts[1] != 434) begin
            n_fail++;
            $display("FAIL b115200_bit n=%0d gap=%0d exp 434",
                bts.size(), bts.size() < 3 ? 0 : bts[2] - bts[1]);
        end
    endtask

    task automatic test_rate_9600();
        int   tr[$];
        logic prev;
        sel  = 3'd2;
        prev = 1'b0;
        for (int i = 0; i < 11000; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL b9600 t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
            if (i > 0 && bc !== prev) tr.push_back(i);
            prev = bc;
        end
        n_checks++;
        if (tr.size() < 4) begin
            n_fail++;
            $display("FAIL b9600_edges got %0d exp >=4", tr.size());
        end else begin
            n_checks++;
            if (tr[0] != 2603) begin
                n_fail++;
                $display("FAIL b9600_first_fall got %0d exp 2603", tr[0]);
            end
            for (int j = 1; j < 4; j++) begin
                n_checks++;
                if (tr[j] - tr[j-1] != 2604) begin
                    n_fail++;
                    $display("FAIL b9600_half%0d got %0d exp 2604",
                        j, tr[j] - tr[j-1]);
                end
            end
        end
    endtask

    task automatic test_custom_clamp();
        int st_last = -1;
        int bt_last = -1;
        int bad_st  = 0;
        int bad_bt  = 0;
        sel  = 3'd7;
        cdiv = {16'd1, 4'd5};
        step();
        n_checks++;
        if (dact !== 20'd32 || rc !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_load div=%0d rc=%b exp 32 1", dact, rc);
        end
        for (int i = 0; i < 200; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL clamp t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
            if (st) begin
                if (st_last >= 0 && t - st_last != 2) bad_st++;
                st_last = t;
            end
            if (bt) begin
                if (bt_last >= 0 && t - bt_last != 32) bad_bt++;
                bt_last = t;
            end
        end
        n_checks++;
        if (bad_st != 0 || bad_bt != 0 || bt_last < 0) begin
            n_fail++;
            $display("FAIL clamp_period bad_st=%0d bad_bt=%0d last_bt=%0d exp 0 0 >=0",
                bad_st, bad_bt, bt_last);
        end
        cdiv = {16'd3, 4'd7};
        step();
        n_checks++;
        if (rc !== 1'b1 || dact !== {16'd3, 4'd7}) begin
            n_fail++;
            $display("FAIL custom_reload rc=%b div=%0d exp 1 55", rc, dact);
        end
        for (int i = 0; i < 150; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL custom t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
        end
    endtask

    task automatic test_switch_midbit();
        int k      = 0;
        int found  = 0;
        int stray  = 0;
        sel = 3'd6;
        step();
        while (n_ticks != 7 && k < 1000) begin
            step();
            k++;
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL switch_pre t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
        end
        n_checks++;
        if (n_ticks != 7) begin
            n_fail++; $display("FAIL switch_wait timeout ticks=%0d exp 7", n_ticks);
        end
        sel = 3'd0;
        step();
        n_checks++;
        if (rc !== 1'b1 || st !== 1'b0 || dact !== 20'd20833) begin
            n_fail++;
            $display("FAIL switch_load rc=%b st=%b div=%0d exp 1 0 20833",
                rc, st, dact);
        end
        k = 0;
        while (found == 0 && k < 1400) begin
            step();
            k++;
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL switch t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
            if (bt) stray++;
            if (st) found = k;
        end
        n_checks++;
        if (found != 1302 || stray != 0) begin
            n_fail++;
            $display("FAIL switch_first got %0d stray=%0d exp 1302 0", found, stray);
        end
    endtask

    task automatic test_enable_drop();
        int k     = 0;
        int bad   = 0;
        int first = 0;
        int nst   = 0;
        int got   = 0;
        sel = 3'd6;
        step();
        while (n_ticks != 5 && k < 600) begin
            step();
            k++;
        end
        n_checks++;
        if (n_ticks != 5) begin
            n_fail++; $display("FAIL en_wait timeout ticks=%0d exp 5", n_ticks);
        end
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL en_low t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
            if (st || bt || bc) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL en_low_quiet got %0d active cycles exp 0", bad);
        end
        en = 1'b1;
        k  = 0;
        while (got == 0 && k < 1000) begin
            step();
            k++;
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL en_rise t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
            if (st) begin
                nst++;
                if (first == 0) first = k;
            end
            if (bt) got = nst;
        end
        n_checks++;
        if (first != 27) begin
            n_fail++; $display("FAIL en_first_tick got %0d exp 27", first);
        end
        n_checks++;
        if (got != 16) begin
            n_fail++; $display("FAIL en_first_bit got %0d ticks exp 16", got);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        while (tick_at(n_ticks + 1, exp_div) != t + 1 - seg_s && k < 100) begin
            step();
            k++;
        end
        n_checks++;
        if (tick_at(n_ticks + 1, exp_div) != t + 1 - seg_s) begin
            n_fail++; $display("FAIL b2b_wait timeout after %0d cycles", k);
        end
        sel = 3'd5;
        step();
        n_checks++;
        if (st !== 1'b0 || rc !== 1'b1 || dact !== 20'd868) begin
            n_fail++;
            $display("FAIL b2b_collide st=%b rc=%b div=%0d exp 0 1 868", st, rc, dact);
        end
        sel = 3'd4;
        step();
        n_checks++;
        if (rc !== 1'b1 || dact !== 20'd1302) begin
            n_fail++; $display("FAIL b2b_second rc=%b div=%0d exp 1 1302", rc, dact);
        end
        sel = 3'd3;
        step();
        n_checks++;
        if (rc !== 1'b1 || dact !== 20'd2604) begin
            n_fail++; $display("FAIL b2b_third rc=%b div=%0d exp 1 2604", rc, dact);
        end
        for (int i = 0; i < 400; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL b2b t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        sel = 3'd6;
        step();
        while (bt !== 1'b1 && k < 1000) begin
            step();
            k++;
        end
        n_checks++;
        if (bt !== 1'b1) begin
            n_fail++; $display("FAIL arst_wait timeout no BaudTick");
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({st, bt, bc, rc} !== 4'b0000 || dact !== 20'd20833) begin
            n_fail++;
            $display("FAIL arst_clear got %b%b%b%b/%0d exp 0000/20833",
                st, bt, bc, rc, dact);
        end
        #1;
        rst_n   = 1'b1;
        seg_s   = t;
        n_ticks = 0;
        exp_div = 20'd20833;
        step();
        n_checks++;
        if (rc !== 1'b1 || dact !== 20'd434) begin
            n_fail++; $display("FAIL arst_reload rc=%b div=%0d exp 1 434", rc, dact);
        end
        for (int i = 0; i < 500; i++) begin
            step();
            n_checks++;
            if ({st, bt, bc, rc, dact} !==
                {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                n_fail++;
                $display("FAIL arst t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                    t, st, bt, bc, rc, dact,
                    exp_st, exp_bt, exp_bc, exp_rc, exp_div);
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 40; r++) begin
            sel  = 3'($urandom_range(0, 7));
            cdiv = {16'($urandom_range(0, 40)), 4'($urandom)};
            en   = ($urandom_range(0, 9) != 0);
            len  = $urandom_range(20, 500);
            for (int i = 0; i < len; i++) begin
                if (sel == 3'd7 && $urandom_range(0, 99) == 0) begin
                    cdiv = {16'($urandom_range(0, 40)), 4'($urandom)};
                end
                step();
                n_checks++;
                if ({st, bt, bc, rc, dact} !==
                    {exp_st, exp_bt, exp_bc, exp_rc, exp_div}) begin
                    n_fail++;
                    $display("FAIL rand r=%0d t=%0d got %b%b%b%b/%0d exp %b%b%b%b/%0d",
                        r, t, st, bt, bc, rc, dact,
                        exp_st, exp_bt, exp_bc, exp_rc, exp_div);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate_115200();
        test_rate_9600();
        test_custom_clamp();
        test_switch_midbit();
        test_enable_drop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
            n_checks, n_fail);
        $finish;
    end

endmodule
